// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag indices, sequencer states and op-class helper for the shared ALU
package alu_pkg;

    localparam int ALU_DATA_W  = 16;
    localparam int ALU_SHAMT_W = 4;
    localparam int ALU_OP_W    = 3;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_NAND = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] OP_INC  = 3'b100;
    localparam logic [ALU_OP_W-1:0] OP_SRA  = 3'b101;
    localparam logic [ALU_OP_W-1:0] OP_SRL  = 3'b110;
    localparam logic [ALU_OP_W-1:0] OP_SLL  = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Shifts leave the architectural flags alone; everything else commits them.
    function automatic logic updates_flags(input logic [ALU_OP_W-1:0] op);
        logic upd;
        case (op)
            OP_SRA, OP_SRL, OP_SLL: upd = 1'b0;
            default:                upd = 1'b1;
        endcase
        return upd;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// rtl/alu_share_ctrl_alu.sv - combinational 16-bit ALU producing result and {Z,V,N}
module alu_share_ctrl_alu
    import alu_pkg::*;
(
    input  logic [ALU_DATA_W-1:0]  data_one,
    input  logic [ALU_DATA_W-1:0]  data_two,
    input  logic [ALU_OP_W-1:0]    control,
    input  logic [ALU_SHAMT_W-1:0] shift,
    output logic [ALU_DATA_W-1:0]  result,
    output logic [2:0]             flags
);

    logic [ALU_DATA_W-1:0] res;
    logic                  ovf;
    logic                  neg;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        neg = 1'b0;
        case (control)
            OP_ADD: begin
                res = data_one + data_two;
                ovf = (data_one[ALU_DATA_W-1] == data_two[ALU_DATA_W-1]) &&
                      (res[ALU_DATA_W-1] != data_one[ALU_DATA_W-1]);
                neg = res[ALU_DATA_W-1];
            end
            OP_SUB: begin
                res = data_one - data_two;
                ovf = (data_one[ALU_DATA_W-1] != data_two[ALU_DATA_W-1]) &&
                      (res[ALU_DATA_W-1] != data_one[ALU_DATA_W-1]);
                neg = res[ALU_DATA_W-1];
            end
            OP_NAND: res = ~(data_one & data_two);
            OP_XOR:  res = data_one ^ data_two;
            OP_INC: begin
                res = data_one + 16'd1;
                ovf = !data_one[ALU_DATA_W-1] && res[ALU_DATA_W-1];
                neg = res[ALU_DATA_W-1];
            end
            OP_SRA: begin
                res = $signed(data_one) >>> shift;
                neg = res[ALU_DATA_W-1];
            end
            OP_SRL: begin
                res = data_one >> shift;
                neg = res[ALU_DATA_W-1];
            end
            default: begin
                res = data_one << shift;
                neg = res[ALU_DATA_W-1];
            end
        endcase
    end

    assign result         = res;
    assign flags[FLAG_Z]  = (res == '0);
    assign flags[FLAG_V]  = ovf;
    assign flags[FLAG_N]  = neg;

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sequencer sharing one ALU between two requesters
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4,
    parameter int OP_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic [OP_W-1:0]    req0_op,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req1_b,
    input  logic [OP_W-1:0]    req1_op,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic [2:0]         rsp_flags,
    output logic [2:0]         flag_reg,
    output logic               busy
);

    state_t             state;
    logic               ptr;
    logic               id_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [OP_W-1:0]    op_q;
    logic [SHAMT_W-1:0] sh_q;
    logic [1:0]         grant;
    logic [DATA_W-1:0]  alu_result;
    logic [2:0]         alu_flags;

    // ptr names the requester that wins a tie; it flips to the other side after each response.
    always_comb begin
        grant = 2'b00;
        if (state == ST_IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;

    alu_share_ctrl_alu u_alu (
        .data_one (a_q),
        .data_two (b_q),
        .control  (op_q),
        .shift    (sh_q),
        .result   (alu_result),
        .flags    (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= 1'b0;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            sh_q       <= '0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_flags  <= 3'b000;
            flag_reg   <= 3'b000;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        id_q  <= grant[1];
                        a_q   <= grant[1] ? req1_a     : req0_a;
                        b_q   <= grant[1] ? req1_b     : req0_b;
                        op_q  <= grant[1] ? req1_op    : req0_op;
                        sh_q  <= grant[1] ? req1_shamt : req0_shamt;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_valid  <= id_q ? 2'b10 : 2'b01;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[id_q]) begin
                        if (updates_flags(op_q)) begin
                            flag_reg <= rsp_flags;
                        end
                        ptr       <= ~id_q;
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [3:0]  req0_shamt = '0, req1_shamt = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic [2:0]  flag_reg;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_shamt (req0_shamt),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_shamt (req1_shamt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .flag_reg   (flag_reg),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op, input logic [3:0] sh);
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_shamt = sh;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_shamt = sh;
        end
    endtask

    // Entered and left just after a rising edge, with the DUT idle.
    task automatic run_op(input string tag, input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic [3:0] sh, input logic [15:0] exp_res,
                          input logic [2:0] exp_flags, input logic [2:0] exp_freg);
        logic [1:0] onehot;
        onehot = (id == 0) ? 2'b01 : 2'b10;
        set_req(id, a, b, op, sh);
        req_valid = onehot;
        @(negedge clk);
        check_eq({tag, "_req_ready"}, req_ready, onehot);
        step();
        req_valid = 2'b00;
        @(negedge clk);
        check_eq({tag, "_exec_rsp_valid"}, rsp_valid, 2'b00);
        check_eq({tag, "_exec_busy"}, busy, 1);
        step();
        @(negedge clk);
        check_eq({tag, "_rsp_valid"}, rsp_valid, onehot);
        check_eq({tag, "_rsp_result"}, rsp_result, exp_res);
        check_eq({tag, "_rsp_flags"}, rsp_flags, exp_flags);
        rsp_ready = onehot;
        step();
        rsp_ready = 2'b00;
        check_eq({tag, "_flag_reg"}, flag_reg, exp_freg);
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_idle_rsp_valid"}, rsp_valid, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         gcnt;
        logic [1:0] gseq [4];

        // Reset state
        do_reset();
        @(negedge clk);
        check_eq("rst_rsp_valid", rsp_valid, 2'b00);
        check_eq("rst_req_ready", req_ready, 2'b00);
        check_eq("rst_rsp_result", rsp_result, 16'h0000);
        check_eq("rst_rsp_flags", rsp_flags, 3'b000);
        check_eq("rst_flag_reg", flag_reg, 3'b000);
        check_eq("rst_busy", busy, 0);
        step();

        // 1: signed overflow on ADD
        run_op("t1_add", 0, 16'h7FFF, 16'h0001, 3'b000, 4'd0, 16'h8000, 3'b011, 3'b011);

        // 2: both continuously valid -> strict alternation starting at requester 0
        do_reset();
        set_req(0, 16'h0001, 16'h0001, 3'b000, 4'd0);
        set_req(1, 16'h0003, 16'h0001, 3'b011, 4'd0);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        gcnt = 0;
        for (int i = 0; i < 4; i++) gseq[i] = 2'b00;
        for (int c = 0; c < 30 && gcnt < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                check_eq("t2_not_both", (req_ready == 2'b11), 0);
                gseq[gcnt] = req_ready;
                gcnt++;
            end
        end
        step();
        req_valid = 2'b00;
        repeat (3) step();
        rsp_ready = 2'b00;
        check_eq("t2_grant_count", gcnt, 4);
        check_eq("t2_grant0", gseq[0], 2'b01);
        check_eq("t2_grant1", gseq[1], 2'b10);
        check_eq("t2_grant2", gseq[2], 2'b01);
        check_eq("t2_grant3", gseq[3], 2'b10);
        check_eq("t2_flag_reg", flag_reg, 3'b000);
        check_eq("t2_busy", busy, 0);

        // 3: SUB to zero commits Z; SRL leaves flag_reg untouched
        run_op("t3_sub", 1, 16'h0005, 16'h0005, 3'b001, 4'd0, 16'h0000, 3'b100, 3'b100);
        run_op("t3_srl", 1, 16'h8000, 16'h0000, 3'b110, 4'd15, 16'h0001, 3'b000, 3'b100);

        // 4: response stalled 10 cycles with req0 waiting; wrong-side rsp_ready ignored
        set_req(1, 16'h00FF, 16'h0000, 3'b100, 4'd0);
        req_valid = 2'b10;
        @(negedge clk);
        check_eq("t4_req_ready_r1", req_ready, 2'b10);
        step();
        set_req(0, 16'h8000, 16'h8000, 3'b000, 4'd0);
        req_valid = 2'b11;
        @(negedge clk);
        check_eq("t4_exec_req_ready", req_ready, 2'b00);
        step();
        rsp_ready = 2'b01;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("t4_stall_rsp_valid", rsp_valid, 2'b10);
            check_eq("t4_stall_result", rsp_result, 16'h0100);
            check_eq("t4_stall_flags", rsp_flags, 3'b000);
            check_eq("t4_stall_req_ready", req_ready, 2'b00);
            check_eq("t4_stall_busy", busy, 1);
        end
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;
        check_eq("t4_inc_flag_reg", flag_reg, 3'b000);
        @(negedge clk);
        check_eq("t4_ptr_grant_r0", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();
        @(negedge clk);
        check_eq("t4_r0_rsp_valid", rsp_valid, 2'b01);
        check_eq("t4_r0_result", rsp_result, 16'h0000);
        check_eq("t4_r0_flags", rsp_flags, 3'b110);
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        check_eq("t4_r0_flag_reg", flag_reg, 3'b110);

        // 5: reset in EXEC discards the op and resets the priority pointer
        set_req(0, 16'h7FFF, 16'h0001, 3'b000, 4'd0);
        req_valid = 2'b01;
        @(negedge clk);
        check_eq("t5_req_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t5_rsp_valid", rsp_valid, 2'b00);
        check_eq("t5_flag_reg", flag_reg, 3'b000);
        check_eq("t5_busy", busy, 0);
        req_valid = 2'b11;
        @(negedge clk);
        check_eq("t5_first_grant", req_ready, 2'b01);
        step();
        do_reset();

        // 6: logical ops report V=N=0
        run_op("t6_nand", 0, 16'hFFFF, 16'hFFFF, 3'b010, 4'd0, 16'h0000, 3'b100, 3'b100);
        run_op("t6_xor", 1, 16'h00FF, 16'h0F0F, 3'b011, 4'd0, 16'h0FF0, 3'b000, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
